pri_grant_ctrl8: RTL and testbench

Eight-channel priority grant controller built around the 8-3 priority encoding scheme: latches active-low requests, picks the highest-numbered eligible channel (channel 7 highest), and holds a one-hot grant plus 3-bit code until the owner acknowledges or a timeout expires. It sits between eight requesters and one shared resource and sequences single ownership of that resource.

---
 rtl/pri_grant_ctrl8.sv | 121 ++++++++++++
 tb/tb_pri_grant_ctrl8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pri_grant_ctrl8.sv
// Purpose : eight-channel priority grant controller; latches active-low requests,
//           grants the highest-numbered eligible channel (ch7 highest) until ack/timeout.
// Latency : request sampled at edge N -> grant registered at edge N+1; 2 dead cycles between grants.
// Backpr. : new grants are held off by iEI=1 or an active grant; pending requests stay latched.
//
// Ports:
//   iClk, iRst_n       clock, asynchronous active-low reset
//   iReq[7:0]          per-channel request, active-low
//   iEI                enable in, active-low (1 blocks new grants)
//   iMask[7:0]         per-channel exclusion, active-high
//   iAck               owner done pulse, active-high, honoured only while granted
//   oGnt[7:0]/oCode    one-hot grant and index of the granted channel
//   oValid             grant valid
//   oTimeout           one-cycle pulse on forced release
//   oEO                enable out, active-low: 0 when enabled, idle and nothing eligible
module pri_grant_ctrl8 #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iReq,
  input  logic       iEI,
  input  logic [7:0] iMask,
  input  logic       iAck,
  output logic [7:0] oGnt,
  output logic [2:0] oCode,
  output logic       oValid,
  output logic       oTimeout,
  output logic       oEO
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] LP_CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_pend;
  logic [TO_W-1:0] r_cnt;

  logic [7:0]      w_elig;
  logic [2:0]      w_win;
  logic            w_rel;
  logic [7:0]      w_clr;

  assign w_elig = r_pend & ~iMask;

  // Ascending scan: the last eligible index seen is the highest, so ch7 wins.
  always_comb begin
    w_win = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (w_elig[k]) begin
        w_win = 3'(k);
      end
    end
  end

  // Release on ack or on the last counted cycle of the grant.
  assign w_rel = (r_state == ST_GRANT) && (iAck || (r_cnt == LP_CNT_LAST));
  assign w_clr = w_rel ? (8'd1 << oCode) : 8'd0;

  assign oEO = ~(~iEI && (r_state == ST_IDLE) && (w_elig == 8'd0));

  // Clear of the released channel dominates a request still held low in that cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pend <= 8'd0;
    end else begin
      r_pend <= (r_pend | ~iReq) & ~w_clr;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      oGnt     <= 8'd0;
      oCode    <= 3'd0;
      oValid   <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      oTimeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!iEI && (w_elig != 8'd0)) begin
            r_state <= ST_GRANT;
            oCode   <= w_win;
            oGnt    <= 8'd1 << w_win;
            oValid  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_GRANT: begin
          r_cnt <= r_cnt + 1'b1;
          if (iAck) begin
            r_state <= ST_RELEASE;
            oGnt    <= 8'd0;
            oValid  <= 1'b0;
          end else if (r_cnt == LP_CNT_LAST) begin
            // Ack on the expiry cycle takes the branch above, so no pulse then.
            r_state  <= ST_RELEASE;
            oGnt     <= 8'd0;
            oValid   <= 1'b0;
            oTimeout <= 1'b1;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pri_grant_ctrl8.sv
// Purpose : directed self-checking bench for pri_grant_ctrl8 with TIMEOUT=4.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : not applicable; stimulus is a fixed linear sequence.
module tb_pri_grant_ctrl8;

  logic       iClk;
  logic       iRst_n;
  logic [7:0] iReq;
  logic       iEI;
  logic [7:0] iMask;
  logic       iAck;
  logic [7:0] oGnt;
  logic [2:0] oCode;
  logic       oValid;
  logic       oTimeout;
  logic       oEO;

  int vectors;
  int miscompares;

  pri_grant_ctrl8 #(.TIMEOUT(4), .TO_W(8)) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iReq     (iReq),
    .iEI      (iEI),
    .iMask    (iMask),
    .iAck     (iAck),
    .oGnt     (oGnt),
    .oCode    (oCode),
    .oValid   (oValid),
    .oTimeout (oTimeout),
    .oEO      (oEO)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    iRst_n = 1'b0;
    iReq   = 8'hFF;
    iEI    = 1'b1;
    iMask  = 8'h00;
    iAck   = 1'b0;

    // Reset state
    #2;
    chk("rst_gnt",   32'(oGnt),     32'h00);
    chk("rst_code",  32'(oCode),    32'h0);
    chk("rst_valid", 32'(oValid),   32'h0);
    chk("rst_to",    32'(oTimeout), 32'h0);
    chk("rst_eo_ei1", 32'(oEO),     32'h1);
    iEI = 1'b0;
    #1;
    chk("rst_eo_ei0", 32'(oEO),     32'h0);
    #9;
    iRst_n = 1'b1;
    tick();

    // Single request on ch2
    iReq = 8'b1111_1011;
    tick();
    iReq = 8'hFF;
    chk("single_not_yet", 32'(oValid), 32'h0);
    chk("single_pend",    32'(dut.r_pend), 32'h04);
    tick();
    chk("single_valid", 32'(oValid), 32'h1);
    chk("single_code",  32'(oCode),  32'h2);
    chk("single_gnt",   32'(oGnt),   32'h04);
    chk("single_eo_busy", 32'(oEO),  32'h1);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chk("single_rel_valid", 32'(oValid), 32'h0);
    chk("single_rel_gnt",   32'(oGnt),   32'h00);
    chk("single_rel_pend",  32'(dut.r_pend), 32'h00);
    chk("single_rel_to",    32'(oTimeout), 32'h0);
    chk("single_rel_code_hold", 32'(oCode), 32'h2);
    chk("single_rel_eo",    32'(oEO), 32'h1);
    tick();
    chk("single_idle_eo",   32'(oEO), 32'h0);

    // Priority: ch5 and ch1 together, ch5 first
    iReq = 8'b1101_1101;
    tick();
    iReq = 8'hFF;
    chk("prio_pend", 32'(dut.r_pend), 32'h22);
    tick();
    chk("prio_first_code", 32'(oCode), 32'h5);
    chk("prio_first_gnt",  32'(oGnt),  32'h20);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chk("prio_gap1", 32'(oValid), 32'h0);
    chk("prio_pend_left", 32'(dut.r_pend), 32'h02);
    tick();
    chk("prio_gap2", 32'(oValid), 32'h0);
    tick();
    chk("prio_second_valid", 32'(oValid), 32'h1);
    chk("prio_second_code",  32'(oCode),  32'h1);
    chk("prio_second_gnt",   32'(oGnt),   32'h02);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    tick();
    chk("prio_idle_valid", 32'(oValid), 32'h0);
    chk("prio_idle_eo",    32'(oEO),    32'h0);

    // Masking and enable
    iEI   = 1'b1;
    iMask = 8'h80;
    iReq  = 8'b0111_1110;
    tick();
    iReq = 8'hFF;
    tick();
    tick();
    chk("ei_block_valid", 32'(oValid), 32'h0);
    chk("ei_block_pend",  32'(dut.r_pend), 32'h81);
    chk("ei_block_eo",    32'(oEO), 32'h1);
    iEI = 1'b0;
    #1;
    chk("ei_on_eo_pending", 32'(oEO), 32'h1);
    tick();
    chk("mask_gnt",  32'(oGnt),  32'h01);
    chk("mask_code", 32'(oCode), 32'h0);
    iMask = 8'h00;
    iAck  = 1'b1;
    tick();
    iAck = 1'b0;
    chk("mask_pend_after", 32'(dut.r_pend), 32'h80);
    tick();
    tick();
    chk("unmask_gnt",  32'(oGnt),  32'h80);
    chk("unmask_code", 32'(oCode), 32'h7);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    tick();
    tick();
    chk("unmask_idle_valid", 32'(oValid), 32'h0);
    chk("unmask_idle_pend",  32'(dut.r_pend), 32'h00);

    // Timeout on ch3 with no ack
    iReq = 8'b1111_0111;
    tick();
    iReq = 8'hFF;
    tick();
    chk("to_gnt", 32'(oGnt), 32'h08);
    for (int i = 0; i < 4; i++) begin
      chk("to_hold_valid", 32'(oValid),   32'h1);
      chk("to_hold_pulse", 32'(oTimeout), 32'h0);
      tick();
    end
    chk("to_expire_valid", 32'(oValid),   32'h0);
    chk("to_expire_pulse", 32'(oTimeout), 32'h1);
    chk("to_expire_pend",  32'(dut.r_pend), 32'h00);
    tick();
    chk("to_pulse_end", 32'(oTimeout), 32'h0);

    // Ack on the expiry cycle: treated as ack, no timeout pulse
    iReq = 8'b1111_0111;
    tick();
    iReq = 8'hFF;
    tick();
    chk("toack_gnt", 32'(oGnt), 32'h08);
    tick();
    tick();
    tick();
    chk("toack_still_valid", 32'(oValid), 32'h1);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chk("toack_valid", 32'(oValid),   32'h0);
    chk("toack_pulse", 32'(oTimeout), 32'h0);
    tick();

    // Reset asserted mid-grant of ch6
    iReq = 8'b1011_1111;
    tick();
    iReq = 8'b1111_1110;
    tick();
    iReq = 8'hFF;
    chk("rstmid_gnt", 32'(oGnt), 32'h40);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(oValid),   32'h0);
    chk("rstmid_gnt0",  32'(oGnt),     32'h00);
    chk("rstmid_pend",  32'(dut.r_pend), 32'h00);
    chk("rstmid_pulse", 32'(oTimeout), 32'h0);
    #1;
    iRst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rstmid_no_regrant", 32'(oValid), 32'h0);
    chk("rstmid_eo",         32'(oEO),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
